// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register-file writeback arbiter.
package regfile_pkg;

  localparam int RF_NUM_REGS = 32;
  localparam int RF_AW       = 5;
  localparam int RF_DW       = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WAIT  = 2'd1,
    ARB_FORCE = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LU   = 2'd2
  } wb_src_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, x0 never busy.
module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int AW       = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [AW-1:0]       set_rd,
  input  logic                clr_en,
  input  logic [AW-1:0]       clr_rd,
  input  logic [AW-1:0]       rs1,
  input  logic [AW-1:0]       rs2,
  input  logic [AW-1:0]       rd,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic                rd_busy,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Addresses beyond NUM_REGS read as not busy.
  function automatic logic hit(input logic [NUM_REGS-1:0] v, input logic [AW-1:0] a);
    hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (a == AW'(i)) hit = v[i];
    end
  endfunction

  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (set_en && set_rd == AW'(i)) busy_d[i] = 1'b1;
      if (clr_en && clr_rd == AW'(i)) busy_d[i] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign rs1_busy = hit(busy_q, rs1);
  assign rs2_busy = hit(busy_q, rs2);
  assign rd_busy  = hit(busy_q, rd);
  assign busy     = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU (fixed priority) and the
// long-latency unit (valid/ready), with hazard stalls and a starvation guard.
//
// state     | meaning
// ARB_IDLE  | long unit not being denied
// ARB_WAIT  | long unit denied, counting consecutive denied cycles
// ARB_FORCE | alu_hold asserted so the long unit gets the next slot
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REGS     = RF_NUM_REGS,
  parameter int AW           = RF_AW,
  parameter int DW           = RF_DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  input  logic          issue_long,
  input  logic [AW-1:0] issue_rd,
  input  logic [AW-1:0] issue_rs1,
  input  logic [AW-1:0] issue_rs2,
  output logic          issue_stall,
  input  logic          alu_we,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_wd,
  input  logic          lu_valid,
  input  logic [AW-1:0] lu_rd,
  input  logic [DW-1:0] lu_wd,
  output logic          lu_ready,
  output logic          alu_hold,
  output logic          WE3,
  output logic [AW-1:0] AD3,
  output logic [DW-1:0] WD3,
  output logic          err
);

  localparam logic [3:0] CNT_LAST = 4'(STARVE_LIMIT - 1);

  arb_state_t          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                alu_hold_q, alu_hold_d;
  logic                err_q, err_d;
  wb_src_t             src;
  logic                commit;
  logic                set_en;
  logic                rs1_busy, rs2_busy, rd_busy;
  logic [NUM_REGS-1:0] busy;
  logic                lu_rd_busy;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (set_en),
    .set_rd   (issue_rd),
    .clr_en   (commit),
    .clr_rd   (lu_rd),
    .rs1      (issue_rs1),
    .rs2      (issue_rs2),
    .rd       (issue_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy),
    .busy     (busy)
  );

  always_comb begin
    lu_rd_busy = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (lu_rd == AW'(i)) lu_rd_busy = busy[i];
    end
  end

  // Write-port mux; everything is held inactive while reset is asserted.
  always_comb begin
    src         = SRC_NONE;
    lu_ready    = 1'b0;
    WE3         = 1'b0;
    AD3         = '0;
    WD3         = '0;
    issue_stall = 1'b0;
    if (rst_n) begin
      lu_ready    = lu_valid & ~alu_we;
      issue_stall = issue_valid & (rs1_busy | rs2_busy | rd_busy);
      if (alu_we)        src = SRC_ALU;
      else if (lu_ready) src = SRC_LU;
      case (src)
        SRC_ALU: begin
          WE3 = (alu_rd != '0);
          AD3 = alu_rd;
          WD3 = alu_wd;
        end
        SRC_LU: begin
          WE3 = (lu_rd != '0);
          AD3 = lu_rd;
          WD3 = lu_wd;
        end
        default: ;
      endcase
    end
  end

  assign commit = lu_valid & lu_ready;
  assign set_en = issue_valid & ~issue_stall & issue_long & (issue_rd != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if ((commit && !lu_rd_busy && lu_rd != '0) || (alu_we && alu_hold_q)) err_d = 1'b1;
    case (state_q)
      ARB_IDLE: begin
        cnt_d = '0;
        if (lu_valid && alu_we) begin
          if (STARVE_LIMIT == 1) begin
            state_d = ARB_FORCE;
          end else begin
            state_d = ARB_WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      ARB_WAIT: begin
        if (commit || !lu_valid) begin
          state_d = ARB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ARB_FORCE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ARB_FORCE: begin
        cnt_d = '0;
        if (commit || !lu_valid) state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end
    endcase
    alu_hold_d = (state_d == ARB_FORCE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      cnt_q      <= '0;
      alu_hold_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_hold_q <= alu_hold_d;
      err_q      <= err_d;
    end
  end

  assign alu_hold = alu_hold_q;
  assign err      = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: mux vector table plus hand-written
// scoreboard, starvation, error and reset sequences.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_long;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_stall;
  logic        alu_we;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wd;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_wd;
  logic        lu_ready, alu_hold, WE3, err;
  logic [4:0]  AD3;
  logic [31:0] WD3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .NUM_REGS(32), .AW(5), .DW(32), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_stall(issue_stall),
    .alu_we(alu_we), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_wd(lu_wd), .lu_ready(lu_ready),
    .alu_hold(alu_hold), .WE3(WE3), .AD3(AD3), .WD3(WD3), .err(err)
  );

  typedef struct {
    logic        alu_we;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wd;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_wd;
    logic        e_we;
    logic [4:0]  e_ad;
    logic [31:0] e_wd;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_long = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    alu_we = 0; alu_rd = 0; alu_wd = 0;
    lu_valid = 0; lu_rd = 0; lu_wd = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h00001234, 1'b0};
    vecs[2] = '{1'b1, 5'd5,  32'h000000AA, 1'b1, 5'd6,  32'hBB,       1'b1, 5'd5,  32'h000000AA, 1'b0};
    vecs[3] = '{1'b0, 5'd4,  32'h00000011, 1'b1, 5'd0,  32'h55,       1'b0, 5'd0,  32'h00000055, 1'b1};
    vecs[4] = '{1'b0, 5'd9,  32'h00000099, 1'b0, 5'd9,  32'h77,       1'b0, 5'd0,  32'h00000000, 1'b0};
    vecs[5] = '{1'b0, 5'd2,  32'h00000022, 1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd31, 32'hCAFEF00D, 1'b1};
    vecs[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd1,  32'h1,        1'b1, 5'd31, 32'hFFFFFFFF, 1'b0};

    idle_inputs();
    rst_n = 0;
    tick();
    // outputs forced low while reset is held, even with an active request
    alu_we = 1; alu_rd = 5'd3; alu_wd = 32'hDEADBEEF; lu_valid = 1; lu_rd = 5'd4;
    issue_valid = 1; issue_rs1 = 5'd4;
    #1;
    chk("rst_we3", WE3, 0);
    chk("rst_ad3", AD3, 0);
    chk("rst_wd3", WD3, 0);
    chk("rst_lu_ready", lu_ready, 0);
    chk("rst_stall", issue_stall, 0);
    tick();
    chk("rst_alu_hold", alu_hold, 0);
    chk("rst_err", err, 0);
    idle_inputs();
    rst_n = 1;
    tick();

    // combinational mux vectors
    for (int i = 0; i < 7; i++) begin
      alu_we = vecs[i].alu_we; alu_rd = vecs[i].alu_rd; alu_wd = vecs[i].alu_wd;
      lu_valid = vecs[i].lu_valid; lu_rd = vecs[i].lu_rd; lu_wd = vecs[i].lu_wd;
      #1;
      chk($sformatf("vec%0d_we3", i), WE3, vecs[i].e_we);
      chk($sformatf("vec%0d_ad3", i), AD3, vecs[i].e_ad);
      chk($sformatf("vec%0d_wd3", i), WD3, vecs[i].e_wd);
      chk($sformatf("vec%0d_lu_ready", i), lu_ready, vecs[i].e_rdy);
      tick();
    end
    idle_inputs();
    do_reset();

    // RAW: long write to x7, then a reader of x7 stalls until after the commit
    issue_valid = 1; issue_long = 1; issue_rd = 5'd7;
    #1;
    chk("raw_issue_nostall", issue_stall, 0);
    tick();
    issue_long = 0; issue_rd = 5'd8; issue_rs1 = 5'd7;
    #1;
    chk("raw_stall", issue_stall, 1);
    lu_valid = 1; lu_rd = 5'd7; lu_wd = 32'h12;
    #1;
    chk("raw_commit_we3", WE3, 1);
    chk("raw_commit_ad3", AD3, 7);
    chk("raw_commit_wd3", WD3, 32'h12);
    chk("raw_stall_same_cycle", issue_stall, 1);
    tick();
    lu_valid = 0;
    #1;
    chk("raw_unstall", issue_stall, 0);
    chk("raw_err", err, 0);
    idle_inputs();
    tick();

    // WAW on x9
    issue_valid = 1; issue_long = 1; issue_rd = 5'd9;
    tick();
    #1;
    chk("waw_stall", issue_stall, 1);
    tick();
    chk("waw_stall_held", issue_stall, 1);
    lu_valid = 1; lu_rd = 5'd9; lu_wd = 32'h99;
    #1;
    chk("waw_stall_commit_cycle", issue_stall, 1);
    tick();
    lu_valid = 0;
    #1;
    chk("waw_unstall", issue_stall, 0);
    tick();
    chk("waw_reissue_busy", issue_stall, 1);
    issue_valid = 0;
    lu_valid = 1; lu_rd = 5'd9;
    tick();
    lu_valid = 0;
    chk("waw_err", err, 0);

    // starvation: long write to x10 denied by a continuous ALU stream
    issue_valid = 1; issue_long = 1; issue_rd = 5'd10;
    tick();
    issue_valid = 0; issue_long = 0;
    lu_valid = 1; lu_rd = 5'd10; lu_wd = 32'h77;
    alu_we = 1; alu_rd = 5'd2; alu_wd = 32'h2;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("starve_ready_c%0d", k), lu_ready, 0);
      chk($sformatf("starve_hold_c%0d", k), alu_hold, 0);
      tick();
    end
    chk("starve_hold", alu_hold, 1);
    alu_we = 0;
    #1;
    chk("starve_ready_forced", lu_ready, 1);
    chk("starve_we3", WE3, 1);
    chk("starve_ad3", AD3, 10);
    tick();
    lu_valid = 0;
    chk("starve_hold_released", alu_hold, 0);
    chk("starve_err", err, 0);

    // unsolicited commit to x12 sets a sticky error
    lu_valid = 1; lu_rd = 5'd12; lu_wd = 32'hC;
    tick();
    lu_valid = 0;
    chk("err_unsolicited", err, 1);
    tick();
    tick();
    chk("err_sticky", err, 1);

    // reset mid-run with busy[5] set and the FSM waiting
    issue_valid = 1; issue_long = 1; issue_rd = 5'd5;
    tick();
    issue_valid = 0; issue_long = 0;
    lu_valid = 1; lu_rd = 5'd6; alu_we = 1; alu_rd = 5'd2; alu_wd = 32'h5;
    tick();
    rst_n = 0;
    #1;
    chk("midrst_we3", WE3, 0);
    chk("midrst_lu_ready", lu_ready, 0);
    tick();
    rst_n = 1;
    idle_inputs();
    #1;
    chk("midrst_err", err, 0);
    chk("midrst_hold", alu_hold, 0);
    issue_valid = 1; issue_rd = 5'd5;
    #1;
    chk("midrst_busy_cleared", issue_stall, 0);
    issue_valid = 0;
    // FSM restarted from idle: hold appears only after four denied cycles
    lu_valid = 1; lu_rd = 5'd0; alu_we = 1; alu_rd = 5'd4; alu_wd = 32'h44;
    tick(); tick(); tick();
    chk("midrst_no_early_hold", alu_hold, 0);
    tick();
    chk("midrst_hold_after_limit", alu_hold, 1);

    // ALU ignoring the hold still writes, flags err, FSM stays forcing
    #1;
    chk("viol_we3", WE3, 1);
    chk("viol_ad3", AD3, 4);
    chk("viol_lu_ready", lu_ready, 0);
    tick();
    chk("viol_err", err, 1);
    chk("viol_hold_kept", alu_hold, 1);
    alu_we = 0;
    tick();
    chk("viol_hold_released", alu_hold, 0);
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Controls the single write port (WE3/AD3/WD3) of the CPU register file. It shares that port between two writeback sources:
- the in-order ALU writeback, which has fixed priority and no backpressure;
- a multi-cycle long-latency unit (load/mul), which uses a valid/ready handshake.

It also keeps a per-register pending-write scoreboard that stalls issue on RAW/WAW hazards, and a starvation FSM that forces a write slot for the long unit.

Parameters:
- NUM_REGS, 32, number of architectural registers (x0 hardwired zero).
- AW, 5, register address width; must satisfy 2**AW >= NUM_REGS.
- DW, 32, data width.
- STARVE_LIMIT, 4, consecutive cycles the long unit may be denied before a slot is forced (range 1..15).

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- issue_valid  in  1  instruction presented at issue.
- issue_long  in  1  issued instruction writes via the long unit.
- issue_rd  in  AW  destination register.
- issue_rs1  in  AW  source register 1.
- issue_rs2  in  AW  source register 2.
- issue_stall  out  1  hazard; issue must hold.
- alu_we  in  1  ALU writeback request (cannot be backpressured).
- alu_rd  in  AW  ALU destination register.
- alu_wd  in  DW  ALU write data.
- lu_valid  in  1  long unit has a result.
- lu_rd  in  AW  long unit destination register.
- lu_wd  in  DW  long unit write data.
- lu_ready  out  1  long unit result accepted this cycle.
- alu_hold  out  1  registered; upstream must keep alu_we=0 this cycle.
- WE3  out  1  register file write enable.
- AD3  out  AW  register file write address.
- WD3  out  DW  register file write data.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset (rst_n=0 at posedge):
  - scoreboard cleared, FSM to ARB_IDLE, starve counter=0, alu_hold=0, err=0.
  - Write-port outputs are combinational and forced to 0 while rst_n=0: WE3=0, AD3=0, WD3=0, lu_ready=0, issue_stall=0.
- Write-port mux (combinational, zero latency):
  - ALU wins whenever alu_we=1.
  - lu_ready = lu_valid & ~alu_we.
  - Source select: alu_we ? ALU : (lu_ready ? LU : none).
  - WE3 = selected & (rd != 0). AD3/WD3 come from the selected source, otherwise 0.
- Long-unit commit: lu_valid & lu_ready. A commit to x0 completes the handshake with no write.
- Scoreboard busy[NUM_REGS-1:0] (registered):
  - Set busy[issue_rd] on issue_valid & ~issue_stall & issue_long & issue_rd != 0.
  - Clear busy[lu_rd] on long-unit commit.
  - busy[0] is always 0.
- issue_stall = issue_valid & (busy[rs1] | busy[rs2] | busy[rd]). Uses the registered busy only.
  - A same-cycle commit does not unstall until the next cycle.
  - Set and clear can therefore never target the same register in one cycle.
- err is set (sticky until reset) when:
  - a long-unit commit arrives with busy[lu_rd]=0 and lu_rd != 0; or
  - alu_we=1 while alu_hold=1. The ALU still wins and the FSM stays in ARB_FORCE.
- Starvation FSM:
  - ARB_IDLE: lu_valid & alu_we -> ARB_WAIT, cnt=1. Otherwise stay, cnt=0.
  - ARB_WAIT:
    - commit or ~lu_valid -> ARB_IDLE, cnt=0;
    - else if cnt == STARVE_LIMIT-1 (at the next edge) -> ARB_FORCE;
    - else cnt++.
  - ARB_FORCE: alu_hold=1. Long-unit commit or ~lu_valid -> ARB_IDLE, cnt=0.
  - STARVE_LIMIT=1: from ARB_IDLE, the first denied cycle goes directly to ARB_FORCE.
  - Worst-case long-unit wait: STARVE_LIMIT+1 cycles, assuming a compliant ALU.
- lu_valid dropping without a commit is a legal withdrawal: FSM returns to ARB_IDLE and the scoreboard is unchanged.

Decomposition:
- Shared package regfile_pkg:
  - AW/DW/NUM_REGS constants;
  - enum arb_state_t {ARB_IDLE, ARB_WAIT, ARB_FORCE};
  - wb_src_t {SRC_NONE, SRC_ALU, SRC_LU}.
- One natural sub-module: reg_scoreboard, holding the busy vector with set/clear ports and three lookup ports (rs1/rs2/rd).
- The arbiter mux and FSM stay in the top module.

Test Plan:
- Reset mid-run: busy[5]=1, FSM in ARB_WAIT, err=1, then rst_n=0 for 1 cycle -> busy all 0, ARB_IDLE, alu_hold=0, err=0; WE3=0 while rst_n=0.
- ALU-only: alu_we=1, alu_rd=3, alu_wd=0xDEADBEEF -> same cycle WE3=1, AD3=3, WD3=0xDEADBEEF. Same with alu_rd=0 -> WE3=0.
- Scoreboard RAW: issue long rd=7. Next cycle issue rs1=7 -> issue_stall=1. Long-unit commit lu_rd=7, lu_wd=0x12 -> WE3=1, AD3=7 that cycle; issue_stall=0 the following cycle.
- WAW stall: busy[9]=1, then issue rd=9 with rs1=rs2=0 -> issue_stall=1 until the commit of x9.
- Starvation, STARVE_LIMIT=4: lu_valid=1 and alu_we=1 held continuously -> lu_ready=0 for 4 cycles, then alu_hold=1. Bench drops alu_we -> lu_ready=1, commit, alu_hold=0 next cycle.
- Protocol errors:
  - long-unit commit lu_rd=12 with busy[12]=0 -> err=1 and it stays set;
  - alu_we=1 during alu_hold -> ALU writes, err=1, FSM remains ARB_FORCE.
